tdc_digital_decoder: RTL
========================

Name: tdc_digital_decoder

Overview:
- Digital back-end of the ADPLL time-to-digital converter.
- Consumes the per-reference-clock samples from tdc_analog: the ripple_count[6:0] DCO cycle counter and the 16-phase ring-oscillator snapshot phase[15:0].
- Decodes each snapshot into a fractional phase and forms an 11-bit modular phase sample.
- Unwraps successive samples into a wide accumulated variable-phase word (tdc_word), used by the phase detector / loop filter downstream.

Parameters:
- RIPPLE_W, 7: width of ripple_count input.
- NPH, 16: number of oscillator phases. Fixed power of two; FRAC_W = log2(NPH) = 4.
- ACC_W, 24: width of the accumulated phase output. Wraps modulo 2^ACC_W.
- ERR_W, 8: width of the saturating code-error counter.

Ports:
- clk  in  1  reference clock (32 MHz); the only clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  decoder enable; low = hold and re-prime.
- ripple_count  in  RIPPLE_W  DCO cycle count sampled by tdc_analog on clk.
- phase  in  NPH  oscillator phase snapshot sampled by tdc_analog on clk.
- tdc_word  out  ACC_W  accumulated phase, in units of 1/NPH DCO period.
- tdc_valid  out  1  one-cycle pulse when tdc_word updates.
- frac  out  FRAC_W  last decoded fractional phase.
- code_err  out  1  one-cycle pulse: current snapshot invalid.
- err_cnt  out  ERR_W  saturating count of invalid snapshots.

Behaviour:
- Reset, asynchronous and active-high; every output is 0 while rst is high. This covers tdc_word, tdc_valid, frac, code_err and err_cnt, plus all internal registers and FSM = IDLE.
- Reset asserted mid-operation clears all state immediately. After release, the block re-primes from IDLE.
- Stage 1, at the clk edge with en=1: register ripple_count and phase into r_cnt and r_ph.
- Stage 2, decode:
  - Valid code: a circular rotation of 0x00FF, i.e. popcount(r_ph) = NPH/2 and exactly one index i with r_ph[i]=1 and r_ph[(i-1) mod NPH]=0.
  - When valid, frac = i.
  - When invalid, pulse code_err, increment err_cnt (saturates at all-ones), and reuse the previous frac.
  - Sample s = {r_cnt, frac}, 11 bits.
- Stage 3, unwrap: d = (s - s_prev) mod 2^11, treated as unsigned, so forward motion of up to 2047 phases per clk is allowed. Then tdc_word += zero-extended d, mod 2^ACC_W, and s_prev <= s.
- Latency: inputs sampled at edge N produce a tdc_word/tdc_valid update at edge N+2.
- FSM:
  - IDLE: entered on reset or when en=0. Pipeline is held, tdc_valid=0, tdc_word holds its value.
  - IDLE -> PRIME when en=1.
  - PRIME: the first decoded sample loads s_prev only. No accumulate, no tdc_valid. Then -> RUN.
  - RUN: accumulate and pulse tdc_valid every cycle.
  - RUN -> IDLE on en=0. Any sample in flight is discarded.
- Simultaneous events:
  - Invalid code in PRIME: s_prev loads using the previous frac (0 after reset), and err_cnt still increments.
  - Wrap-around: ripple_count rolling over 127 -> 0 is absorbed by the modular subtraction. tdc_word rolls over silently.

Decomposition:
- Package tdc_pkg holds:
  - constants NPH, FRAC_W, RIPPLE_W, SAMPLE_W = RIPPLE_W + FRAC_W;
  - enum tdc_state_t {IDLE, PRIME, RUN};
  - function is_valid_therm().
- Sub-module tdc_therm_decode: combinational NPH-bit snapshot -> {frac, valid}. It is instantiated in stage 2 and separately unit-tested.

Test Plan:
- Reset: hold rst high with random inputs -> all outputs 0. Release with en=0 -> tdc_valid stays 0.
- Priming and latency:
  - Stimulus: en=1; cycle 0 drives ripple=0, phase=0x00FF; cycle 1 drives ripple=78, phase=0x03FC (s=1250).
  - Required: the first sample produces no tdc_valid; the tdc_valid pulse appears two edges after cycle 1 with tdc_word=1250.
- Steady 2.5 GHz, +1250 phases per clk: 10 valids -> tdc_word=12500. Intermediate samples cross ripple wrap 127 -> 0 with no discontinuity.
- Invalid code:
  - Stimulus: phase=0x00F7 in RUN.
  - Required: code_err pulses once, err_cnt=1, frac held, and the delta uses the old frac. Drive 300 invalid codes -> err_cnt saturates at 255.
- en toggle: en low for 5 cycles mid-RUN, then high -> tdc_word frozen, a one-sample re-prime with no jump, and accumulation resumes from the frozen value.
- Accumulator wrap: preload by running until tdc_word is near 2^24 - 100, then add 1250 -> tdc_word=1150.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared constants, FSM state type and snapshot check for the TDC decoder.
// Thermometer snapshots are valid only as a rotation of a half-ones word.
package tdc_pkg;

  localparam int RIPPLE_W = 7;
  localparam int NPH      = 16;
  localparam int FRAC_W   = $clog2(NPH);
  localparam int SAMPLE_W = RIPPLE_W + FRAC_W;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } tdc_state_t;

  function automatic logic is_valid_therm(
    input logic [NPH-1:0] ph
  );
    int ones;
    int rises;
    logic [FRAC_W-1:0] k;
    logic [FRAC_W-1:0] km1;
    ones  = 0;
    rises = 0;
    for (int i = 0; i < NPH; i++) begin
      k   = FRAC_W'(i);
      km1 = k - 1'b1;
      if (ph[k]) ones++;
      if (ph[k] && !ph[km1]) rises++;
    end
    return (ones == NPH / 2) && (rises == 1);
  endfunction

endpackage

// File: rtl/tdc_therm_decode.sv
// Combinational snapshot decoder: ring-oscillator phase word to frac index.
// frac is the position of the single 0->1 edge walking up the ring.
module tdc_therm_decode
  import tdc_pkg::*;
(
  input  logic [NPH-1:0]    ph_i,
  output logic [FRAC_W-1:0] frac_o,
  output logic              valid_o
);

  logic [FRAC_W-1:0] k;
  logic [FRAC_W-1:0] km1;

  always_comb begin
    frac_o = '0;
    k      = '0;
    km1    = '0;
    for (int i = 0; i < NPH; i++) begin
      k   = FRAC_W'(i);
      km1 = k - 1'b1;
      if (ph_i[k] && !ph_i[km1]) frac_o = k;
    end
    valid_o = is_valid_therm(ph_i);
  end

endmodule

// File: rtl/tdc_digital_decoder.sv
// TDC back-end: capture, decode and unwrap ripple/phase samples into an
// accumulated phase word; three pipeline stages gated by a prime FSM.
module tdc_digital_decoder
  import tdc_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int ERR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [RIPPLE_W-1:0] ripple_count,
  input  logic [NPH-1:0]      phase,
  output logic [ACC_W-1:0]    tdc_word,
  output logic                tdc_valid,
  output logic [FRAC_W-1:0]   frac,
  output logic                code_err,
  output logic [ERR_W-1:0]    err_cnt
);

  tdc_state_t state_q, state_d;

  logic                v1_q;
  logic [RIPPLE_W-1:0] r_cnt_q;
  logic [NPH-1:0]      r_ph_q;

  logic                v2_q;
  logic [SAMPLE_W-1:0] s_q;
  logic [FRAC_W-1:0]   frac_q;
  logic                cerr_q;
  logic [ERR_W-1:0]    err_q;

  logic [SAMPLE_W-1:0] sprev_q;
  logic [ACC_W-1:0]    word_q;
  logic                valid_q;

  logic [FRAC_W-1:0]   dec_frac;
  logic                dec_ok;
  logic [SAMPLE_W-1:0] delta;
  logic                prime_ld;
  logic                acc;

  tdc_therm_decode u_dec (
    .ph_i    (r_ph_q),
    .frac_o  (dec_frac),
    .valid_o (dec_ok)
  );

  // Modular difference absorbs ripple counter roll-over.
  assign delta = s_q - sprev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    prime_ld = 1'b0;
    acc      = 1'b0;
    unique case (state_q)
      IDLE: if (en) state_d = PRIME;
      PRIME: begin
        if (!en) begin
          state_d = IDLE;
        end else if (v2_q) begin
          prime_ld = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (!en) state_d = IDLE;
        else     acc = v2_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      r_cnt_q <= '0;
      r_ph_q  <= '0;
      v2_q    <= 1'b0;
      s_q     <= '0;
      frac_q  <= '0;
      cerr_q  <= 1'b0;
      err_q   <= '0;
      sprev_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else if (!en) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      cerr_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      r_cnt_q <= ripple_count;
      r_ph_q  <= phase;
      v1_q    <= 1'b1;
      v2_q    <= v1_q;
      cerr_q  <= 1'b0;
      valid_q <= 1'b0;
      if (v1_q) begin
        if (dec_ok) begin
          s_q    <= {r_cnt_q, dec_frac};
          frac_q <= dec_frac;
        end else begin
          s_q    <= {r_cnt_q, frac_q};
          cerr_q <= 1'b1;
          if (err_q != '1) err_q <= err_q + 1'b1;
        end
      end
      if (prime_ld) sprev_q <= s_q;
      if (acc) begin
        sprev_q <= s_q;
        word_q  <= word_q + ACC_W'(delta);
        valid_q <= 1'b1;
      end
    end
  end

  assign tdc_word  = word_q;
  assign tdc_valid = valid_q;
  assign frac      = frac_q;
  assign code_err  = cerr_q;
  assign err_cnt   = err_q;

endmodule
